// File: rtl/tapdelay_pkg.sv
// Shared constants for the tap-delay counter bank: default geometry and the
// direction encoding used on the dir inputs.
package tapdelay_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_WIDTH     = 5;
    localparam int DEF_INIT_VAL  = 0;
    localparam int DEF_TERM_INIT = 16;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/tapdelay_counter_ch.sv
// One modulo-(term+1) up/down counter channel with load and a registered
// wrap pulse that coincides with the wrapped count value.
module tapdelay_counter_ch
    import tapdelay_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int INIT_VAL = DEF_INIT_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] r_count = WIDTH'(INIT_VAL);
    logic             r_wrap  = 1'b0;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_wrap_nxt;

    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (ld) begin
            w_count_nxt = (ld_val > term) ? term : ld_val;
        end else if (en) begin
            if (dir == DIR_UP) begin
                // >= also recovers a count stranded above a lowered term
                if (r_count >= term) begin
                    w_count_nxt = '0;
                    w_wrap_nxt  = 1'b1;
                end else begin
                    w_count_nxt = r_count + WIDTH'(1);
                end
            end else begin
                if (r_count == '0) begin
                    w_count_nxt = term;
                    w_wrap_nxt  = 1'b1;
                end else if (r_count > term) begin
                    w_count_nxt = term;
                end else begin
                    w_count_nxt = r_count - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= WIDTH'(INIT_VAL);
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;

endmodule

// File: rtl/tapdelay_counter_bank.sv
// Bank of NUM_CH independent counter channels sharing one programmable
// terminal count register.
module tapdelay_counter_bank
    import tapdelay_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int INIT_VAL  = DEF_INIT_VAL,
    parameter int TERM_INIT = DEF_TERM_INIT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH-1:0]       ld,
    input  logic [WIDTH-1:0]        ld_val,
    input  logic                    term_wr,
    input  logic [WIDTH-1:0]        term_val,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       wrap,
    output logic [WIDTH-1:0]        term
);

    logic [WIDTH-1:0] r_term = WIDTH'(TERM_INIT);

    // Channels see r_term, so a write this cycle only affects the next one
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_term <= WIDTH'(TERM_INIT);
        end else if (term_wr) begin
            r_term <= term_val;
        end
    end

    assign term = r_term;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        tapdelay_counter_ch #(
            .WIDTH    (WIDTH),
            .INIT_VAL (INIT_VAL)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[g]),
            .dir    (dir[g]),
            .ld     (ld[g]),
            .ld_val (ld_val),
            .term   (r_term),
            .count  (count[g*WIDTH +: WIDTH]),
            .wrap   (wrap[g])
        );
    end

endmodule

// File: tb/tb_tapdelay_counter_bank.sv
// Bench for tapdelay_counter_bank: vector table, directed corner sequences,
// a small two-bit build, and randomized traffic against an integer model.
module tb_tapdelay_counter_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  en = '0, dir = '0, ld = '0;
    logic [4:0]  ld_val = '0, term_val = '0;
    logic        term_wr = 1'b0;
    logic [19:0] count;
    logic [3:0]  wrap;
    logic [4:0]  term;

    logic        s_rst = 1'b0;
    logic        s_en = 1'b0;
    logic [1:0]  s_count;
    logic        s_wrap;
    logic [1:0]  s_term;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tapdelay_counter_bank u_dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .ld(ld), .ld_val(ld_val),
        .term_wr(term_wr), .term_val(term_val), .count(count), .wrap(wrap), .term(term)
    );

    tapdelay_counter_bank #(.NUM_CH(1), .WIDTH(2), .INIT_VAL(0), .TERM_INIT(3)) u_small (
        .clk(clk), .rst(s_rst), .en(s_en), .dir(1'b0), .ld(1'b0), .ld_val(2'd0),
        .term_wr(1'b0), .term_val(2'd0), .count(s_count), .wrap(s_wrap), .term(s_term)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        en = '0; dir = '0; ld = '0; ld_val = '0; term_wr = 1'b0; term_val = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    function automatic logic [4:0] cnt(input int ch);
        return count[ch*5 +: 5];
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  en, dir, ld;
        logic [4:0]  ld_val;
        logic        term_wr;
        logic [4:0]  term_val;
        logic [19:0] exp_count;
        logic [3:0]  exp_wrap;
        logic [4:0]  exp_term;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    int m_cnt[4];
    int m_wrap[4];
    int m_term;

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_cnt[c] = 0;
            m_wrap[c] = 0;
        end
        m_term = 16;
    endtask

    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < 4; c++) begin
                m_wrap[c] = 0;
                if (ld[c]) begin
                    m_cnt[c] = (int'(ld_val) < m_term) ? int'(ld_val) : m_term;
                end else if (en[c] && !dir[c]) begin
                    if (m_cnt[c] >= m_term) begin m_cnt[c] = 0; m_wrap[c] = 1; end
                    else m_cnt[c] = m_cnt[c] + 1;
                end else if (en[c]) begin
                    if (m_cnt[c] == 0) begin m_cnt[c] = m_term; m_wrap[c] = 1; end
                    else if (m_cnt[c] > m_term) m_cnt[c] = m_term;
                    else m_cnt[c] = m_cnt[c] - 1;
                end
            end
            if (term_wr) m_term = int'(term_val);
        end
    endtask

    initial begin
        logic [19:0] exp_cnt_v;
        logic [3:0]  exp_wrap_v;

        //            rst   en       dir      ld       ldv    twr  tv    exp_count                          wrap     term
        vecs[0] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 5'd0,  1'b0, 5'd0, {5'd0, 5'd0, 5'd0, 5'd0},         4'b0000, 5'd16};
        vecs[1] = '{1'b1, 4'b1111, 4'b1010, 4'b0000, 5'd0,  1'b0, 5'd0, {5'd16, 5'd1, 5'd16, 5'd1},       4'b1010, 5'd16};
        vecs[2] = '{1'b1, 4'b1110, 4'b1010, 4'b0001, 5'd31, 1'b0, 5'd0, {5'd15, 5'd2, 5'd15, 5'd16},      4'b0000, 5'd16};
        vecs[3] = '{1'b1, 4'b1111, 4'b0000, 4'b0000, 5'd0,  1'b1, 5'd3, {5'd16, 5'd3, 5'd16, 5'd0},       4'b0001, 5'd3};
        vecs[4] = '{1'b1, 4'b1111, 4'b1000, 4'b0000, 5'd0,  1'b0, 5'd0, {5'd3, 5'd0, 5'd0, 5'd1},         4'b0110, 5'd3};
        vecs[5] = '{1'b1, 4'b0000, 4'b0000, 4'b1111, 5'd2,  1'b0, 5'd0, {5'd2, 5'd2, 5'd2, 5'd2},         4'b0000, 5'd3};
        vecs[6] = '{1'b0, 4'b1111, 4'b0000, 4'b1111, 5'd9,  1'b1, 5'd7, {5'd0, 5'd0, 5'd0, 5'd0},         4'b0000, 5'd16};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; dir = vecs[i].dir; ld = vecs[i].ld;
            ld_val = vecs[i].ld_val; term_wr = vecs[i].term_wr; term_val = vecs[i].term_val;
            tick();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
            chk($sformatf("vec%0d_wrap", i),  32'(wrap),  32'(vecs[i].exp_wrap));
            chk($sformatf("vec%0d_term", i),  32'(term),  32'(vecs[i].exp_term));
        end
        rst = 1'b1;

        // Up count through one full period and a bit
        do_reset();
        en = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk($sformatf("up_seq%0d", i), 32'(cnt(0)), (i < 16) ? i + 1 : i - 16);
            chk($sformatf("up_wrap%0d", i), 32'(wrap), (i == 16) ? 32'h1 : 32'h0);
        end
        chk("up_ch1_idle", 32'(cnt(1)), 0);

        // Down count from zero wraps to term
        do_reset();
        en = 4'b0010; dir = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("down_seq%0d", i), 32'(cnt(1)), 16 - i);
            chk($sformatf("down_wrap%0d", i), 32'(wrap), (i == 0) ? 32'h2 : 32'h0);
        end

        // Term lowered mid-count: old term applies on the write cycle
        do_reset();
        ld = 4'b0100; ld_val = 5'd10;
        tick();
        ld = '0; en = 4'b0100; term_wr = 1'b1; term_val = 5'd5;
        tick();
        chk("term_old_count", 32'(cnt(2)), 11);
        chk("term_old_term", 32'(term), 5);
        term_wr = 1'b0;
        tick();
        chk("term_recover_count", 32'(cnt(2)), 0);
        chk("term_recover_wrap", 32'(wrap), 32'h4);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("term5_seq%0d", i), 32'(cnt(2)), (i <= 5) ? i : 0);
            chk($sformatf("term5_wrap%0d", i), 32'(wrap), (i == 6) ? 32'h4 : 32'h0);
        end

        // Load saturates at term and beats enable
        do_reset();
        ld = 4'b1001; ld_val = 5'd31; en = 4'b1000;
        tick();
        chk("ld_sat_ch3", 32'(cnt(3)), 16);
        chk("ld_sat_ch0", 32'(cnt(0)), 16);
        chk("ld_sat_wrap", 32'(wrap), 0);

        // Term of zero: up counter pins at 0 and wraps every enabled cycle
        do_reset();
        term_wr = 1'b1; term_val = 5'd0;
        tick();
        term_wr = 1'b0; en = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("term0_count%0d", i), 32'(cnt(0)), 0);
            chk($sformatf("term0_wrap%0d", i), 32'(wrap), 32'h1);
        end

        // Two-bit, single channel build
        s_rst = 1'b0;
        tick();
        chk("small_rst_count", 32'(s_count), 0);
        chk("small_rst_term", 32'(s_term), 3);
        s_rst = 1'b1; s_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("small_seq%0d", i), 32'(s_count), (i + 1) % 4);
            chk($sformatf("small_wrap%0d", i), 32'(s_wrap), ((i + 1) % 4 == 0) ? 1 : 0);
        end
        s_en = 1'b0;

        // Randomized traffic against the integer model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 39) != 0);
            en       = 4'($urandom);
            dir      = 4'($urandom);
            ld       = 4'($urandom) & 4'($urandom) & 4'($urandom);
            ld_val   = 5'($urandom);
            term_wr  = ($urandom_range(0, 9) == 0);
            term_val = 5'($urandom_range(0, 31));
            model_step();
            tick();
            for (int c = 0; c < 4; c++) begin
                exp_cnt_v[c*5 +: 5] = 5'(m_cnt[c]);
                exp_wrap_v[c]       = (m_wrap[c] != 0);
            end
            chk($sformatf("rnd%0d_count", i), 32'(count), 32'(exp_cnt_v));
            chk($sformatf("rnd%0d_wrap", i), 32'(wrap), 32'(exp_wrap_v));
            chk($sformatf("rnd%0d_term", i), 32'(term), 32'(m_term));
        end
        idle_inputs();
        rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tapdelay_counter_bank.md
TAPDELAY_COUNTER_BANK -- requirements
Module: tapdelay_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent counter channels, range 1..32.
REQ-002 Parameter WIDTH, default 5: per-channel count width in bits, range 2..16.
REQ-003 Parameter INIT_VAL, default 0: reset and clear value of every channel; SHALL be <= TERM_INIT.
REQ-004 Parameter TERM_INIT, default 16: reset value of the shared terminal count; SHALL be < 2^WIDTH.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 en  input  NUM_CH  per-channel count enable.
REQ-008 dir  input  NUM_CH  per-channel direction: 0 = up, 1 = down.
REQ-009 ld  input  NUM_CH  per-channel load strobe.
REQ-010 ld_val  input  WIDTH  load value, shared by all channels strobed in that cycle.
REQ-011 term_wr  input  1  terminal count write strobe.
REQ-012 term_val  input  WIDTH  new terminal count value.
REQ-013 count  output  NUM_CH*WIDTH  registered counts; channel i at bits [i*WIDTH +: WIDTH].
REQ-014 wrap  output  NUM_CH  registered one-cycle pulse, per channel, on wrap-around.
REQ-015 term  output  WIDTH  currently active terminal count.

Function
REQ-016 Each channel SHALL cycle through TERM+1 states, 0..TERM inclusive; with the defaults this gives 17 states, 0..16.
REQ-017 Channel update priority per cycle SHALL be: rst, then ld, then en, then hold.
REQ-018 Up count, en=1, dir=0: if count >= term, next = 0 and wrap=1; otherwise next = count+1.
REQ-019 Down count, en=1, dir=1: if count == 0, next = term and wrap=1; if count > term, next = term with wrap=0; otherwise next = count-1.
REQ-020 Load, ld=1: next = min(ld_val, term), wrap=0, regardless of en and dir.
REQ-021 Hold, ld=0 and en=0: count unchanged, wrap=0.
REQ-022 wrap[i] SHALL assert in the same cycle the wrapped count value appears on count, and SHALL be 0 in every other cycle.
REQ-023 Latency: count and wrap SHALL reflect inputs sampled at edge N from edge N onward; there is no combinational input-to-output path.
REQ-024 term_wr=1 SHALL load term_val into term at the edge; channel decisions in that same cycle SHALL use the old term.
REQ-025 term_val=0 is legal: up-counting channels then hold 0 and pulse wrap on every enabled cycle.
REQ-026 Lowering term below a channel's current count SHALL NOT modify that count directly; REQ-018 and REQ-019 govern its recovery on the next enabled step.
REQ-027 Channels SHALL be fully independent; simultaneous ld, en or wrap on any subset SHALL NOT interact.
REQ-028 Arithmetic SHALL be WIDTH bits, unsigned; no intermediate result SHALL overflow, since count+1 is only formed when count < term <= 2^WIDTH-1.

Reset
REQ-029 When rst=0 at an edge: every count = INIT_VAL, wrap = 0, term = TERM_INIT.
REQ-030 Reset SHALL override ld, en and term_wr in the same cycle, including mid-count.
REQ-031 Registers SHALL power up to the reset values for FPGA targets.

Structure
REQ-032 A package tapdelay_pkg SHALL hold the default constants (NUM_CH, WIDTH, INIT_VAL, TERM_INIT) and the direction encoding constants DIR_UP and DIR_DOWN.
REQ-033 A sub-module tapdelay_counter_ch SHALL implement one channel (count register, wrap register, next-state logic) and be instantiated NUM_CH times via generate.
REQ-034 The term register and its write logic SHALL live in the top level and be shared by all channels.

Verification
REQ-035 Defaults; rst low 1 cycle; en[0]=1, dir=0 for 20 cycles -> count0 sequence 1..16, 0, 1, 2, 3; wrap[0] high only in the cycle count0=0.
REQ-036 dir[1]=1, en[1]=1 from count1=0 -> count1=16 with wrap[1]=1, then 15, 14, ...
REQ-037 Defaults; term_wr=1, term_val=5 while count2=10 and en[2]=1 with dir=0 -> count2=11 (old term used), next step 0 with wrap[2]=1, then 1..5, 0.
REQ-038 ld[3]=1, ld_val=31, en[3]=1, term=16 -> count3=16, wrap[3]=0; same cycle ld[0]=1, ld_val=31 with en[0]=0 -> count0=16.
REQ-039 rst=0 asserted with ld=all, en=all, term_wr=1 -> all counts=0, wrap=0, term=16 next cycle.
REQ-040 NUM_CH=1, WIDTH=2, TERM_INIT=3 build; up count -> 0, 1, 2, 3, 0 with a single wrap per period.
